// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM dimmer.
package led_pwm_pkg;

    // Per-channel duty source selector
    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_BREATH = 1'b1;

    // Default build parameters
    localparam int DEFAULT_N_CH       = 2;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE   = 4;
    localparam int DEFAULT_BREATH_DIV = 2;

    // Next breathing direction (1 = down).
    // The level always moves one step in the returned direction, so the
    // endpoints are visited once: up at the top turns down, down at zero
    // turns up.
    function automatic logic breath_next_dir(input logic dir_down,
                                             input logic at_top,
                                             input logic at_bottom);
        logic nxt;
        nxt = dir_down;
        if (!dir_down && at_top) begin
            nxt = 1'b1;
        end else if (dir_down && at_bottom) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM output channel: per-period shadow duty, compare and LED flop.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic             mode,
    input  logic [WIDTH-1:0] pwm_cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] breath_level,
    output logic             led
);

    logic [WIDTH-1:0] shadow_duty;

    // Load the duty for the coming period at the wrap so mid-period edits
    // cannot glitch the output; compare against the shared counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty <= '0;
            led         <= 1'b0;
        end else begin
            if (wrap) begin
                shadow_duty <= (mode == MODE_BREATH) ? breath_level : duty;
            end
            led <= en & (pwm_cnt < shadow_duty);
        end
    end

endmodule

// File: rtl/led_pwm_dimmer.sv
// Multi-channel LED PWM dimmer with static and breathing duty modes.
// Prescaler, PWM counter and breathing ramp are shared by all channels.
module led_pwm_dimmer
    import led_pwm_pkg::*;
#(
    parameter int N_CH       = DEFAULT_N_CH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int BREATH_DIV = DEFAULT_BREATH_DIV
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [N_CH*WIDTH-1:0] DUTY,
    input  logic [N_CH-1:0]       MODE,
    output logic [N_CH-1:0]       LED,
    output logic                  PERIOD_START,
    output logic                  USBPU
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIV_W = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BREATH_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0] prescaler;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] breath_level;
    logic             breath_dir_down;
    logic [DIV_W-1:0] breath_div_cnt;
    logic             tick;
    logic             wrap;
    logic             breath_step;
    logic             breath_dir_nxt;

    assign tick        = EN && (prescaler == PRE_LAST);
    assign wrap        = tick && (pwm_cnt == CNT_LAST);
    assign breath_step = wrap && (breath_div_cnt == DIV_LAST);

    assign breath_dir_nxt = breath_next_dir(breath_dir_down,
                                            breath_level == CNT_LAST,
                                            breath_level == '0);

    // USB is not used on this board; keep the pull-up off.
    assign USBPU = 1'b0;

    // Shared timebase: prescaler, PWM counter and the registered wrap strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            PERIOD_START <= 1'b0;
        end else begin
            PERIOD_START <= wrap;
            if (EN) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Breathing ramp: one level step every BREATH_DIV periods. Channels latch
    // the level on the same wrap, so they see the pre-step value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            breath_div_cnt  <= '0;
            breath_level    <= '0;
            breath_dir_down <= 1'b0;
        end else if (wrap) begin
            breath_div_cnt <= (breath_div_cnt == DIV_LAST) ? '0 : breath_div_cnt + 1'b1;
            if (breath_step) begin
                breath_dir_down <= breath_dir_nxt;
                breath_level    <= breath_dir_nxt ? breath_level - 1'b1
                                                  : breath_level + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk         (CLK),
            .rst         (RST),
            .en          (EN),
            .wrap        (wrap),
            .mode        (MODE[i]),
            .pwm_cnt     (pwm_cnt),
            .duty        (DUTY[i*WIDTH +: WIDTH]),
            .breath_level(breath_level),
            .led         (LED[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer: static duty, shadow update, prescaler
// with EN freeze, breathing ramp and mid-operation reset.
module tb_led_pwm_dimmer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [7:0] d0;
    logic [7:0] d1;
    int         sel;

    logic [1:0] led_a;
    logic       led_b;
    logic       led_c;
    logic       ps_a, ps_b, ps_c;
    logic       usb_a, usb_b, usb_c;
    logic [1:0] led_mon;
    logic       ps_mon;

    int checks = 0;
    int errors = 0;

    // A: WIDTH=4, PRESCALE=1, two static channels
    led_pwm_dimmer #(.N_CH(2), .WIDTH(4), .PRESCALE(1), .BREATH_DIV(1)) dut_a (
        .CLK(clk), .RST(rst), .EN(en), .DUTY({d1[3:0], d0[3:0]}), .MODE(2'b00),
        .LED(led_a), .PERIOD_START(ps_a), .USBPU(usb_a));

    // B: WIDTH=4, PRESCALE=3, one static channel
    led_pwm_dimmer #(.N_CH(1), .WIDTH(4), .PRESCALE(3), .BREATH_DIV(1)) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .DUTY(d0[3:0]), .MODE(1'b0),
        .LED(led_b), .PERIOD_START(ps_b), .USBPU(usb_b));

    // C: WIDTH=3, PRESCALE=1, one breathing channel
    led_pwm_dimmer #(.N_CH(1), .WIDTH(3), .PRESCALE(1), .BREATH_DIV(1)) dut_c (
        .CLK(clk), .RST(rst), .EN(en), .DUTY(d0[2:0]), .MODE(1'b1),
        .LED(led_c), .PERIOD_START(ps_c), .USBPU(usb_c));

    always_comb begin
        led_mon = 2'b00;
        ps_mon  = 1'b0;
        case (sel)
            0:       begin led_mon = led_a;         ps_mon = ps_a; end
            1:       begin led_mon = {1'b0, led_b}; ps_mon = ps_b; end
            default: begin led_mon = {1'b0, led_c}; ps_mon = ps_c; end
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until the next PERIOD_START, bounded.
    task automatic wait_ps(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ps_mon && cycles < 500);
    endtask

    // Called on a negedge where PERIOD_START is high; samples one full period
    // and returns on the negedge of the next PERIOD_START.
    task automatic measure(input int chg_at, input int chg_val, input int off_at,
                           output int len, output int hi0, output int hi1,
                           output int rises0, output int hi_off);
        logic prev0;
        len = 0; hi0 = 0; hi1 = 0; rises0 = 0; hi_off = 0;
        prev0 = led_mon[0];
        do begin
            if (led_mon[0]) hi0++;
            if (led_mon[1]) hi1++;
            if (led_mon[0] && !prev0) rises0++;
            if (!en && led_mon[0]) hi_off++;
            prev0 = led_mon[0];
            if (chg_at >= 0 && len == chg_at) d0 = 8'(chg_val);
            if (off_at >= 0 && len == off_at) en = 1'b0;
            if (off_at >= 0 && len == off_at + 10) en = 1'b1;
            len++;
            @(negedge clk);
        end while (!ps_mon && len < 200);
    endtask

    int cyc, len, h0, h1, r0, ho;
    int hist[22];
    int exp_breath[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int peak1, peak2;

    initial begin
        // ---------------- A: static duty, WIDTH=4, PRESCALE=1
        sel = 0; rst = 1'b1; en = 1'b1; d0 = 8'd4; d1 = 8'd0;
        repeat (3) @(negedge clk);
        check("a_rst_led", led_mon, 0);
        check("a_rst_ps", ps_mon, 0);
        check("usbpu", {usb_a, usb_b, usb_c}, 0);
        rst = 1'b0;
        wait_ps(cyc);
        check("a_first_ps", cyc, 16);

        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("a_len", len, 16);
        check("a_hi0_d4", h0, 4);
        check("a_hi1_d0", h1, 0);
        check("a_rise_d4", r0, 1);

        d0 = 8'd15;
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("a_hi0_before_d15", h0, 4);
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("a_len_d15", len, 16);
        check("a_hi0_d15", h0, 15);
        check("a_hi1_d0_again", h1, 0);

        // Shadow update: change 4 -> 12 when pwm_cnt = 7
        d0 = 8'd4;
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("a_hi0_d15_tail", h0, 15);
        measure(7, 12, -1, len, h0, h1, r0, ho);
        check("a_shadow_keep", h0, 4);
        check("a_shadow_keep_rise", r0, 1);
        check("a_shadow_keep_len", len, 16);
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("a_shadow_new", h0, 12);
        check("a_shadow_new_rise", r0, 1);

        // ---------------- B: PRESCALE=3, duty 2, EN freeze
        sel = 1; d0 = 8'd2; rst = 1'b1;
        repeat (2) @(negedge clk);
        check("b_rst_led", led_mon, 0);
        rst = 1'b0;
        wait_ps(cyc);
        check("b_first_ps", cyc, 48);
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("b_len", len, 48);
        check("b_hi0", h0, 6);
        measure(-1, 0, 2, len, h0, h1, r0, ho);
        check("b_en_len", len, 58);
        check("b_en_hi0", h0, 6);
        check("b_en_off_led", ho, 0);
        measure(-1, 0, -1, len, h0, h1, r0, ho);
        check("b_resume_len", len, 48);
        check("b_resume_hi0", h0, 6);

        // ---------------- C: breathing, WIDTH=3
        sel = 2; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ps(cyc);
        check("c_first_ps", cyc, 8);
        for (int p = 0; p < 22; p++) begin
            measure(-1, 0, -1, len, h0, h1, r0, ho);
            hist[p] = h0;
        end
        for (int p = 0; p < 16; p++) begin
            check($sformatf("c_breath_%0d", p), hist[p], exp_breath[p]);
        end
        peak1 = -1; peak2 = -1;
        for (int p = 0; p < 22; p++) begin
            if (hist[p] == 7) begin
                if (peak1 < 0) peak1 = p;
                else if (peak2 < 0) peak2 = p;
            end
        end
        check("c_peak_gap", peak2 - peak1, 14);

        // Mid-operation reset: period 22 has shadow 6, level 5
        repeat (2) @(negedge clk);
        check("c_pre_rst_led", led_mon, 1);
        rst = 1'b1;
        @(negedge clk);
        check("c_rst_led", led_mon, 0);
        check("c_rst_ps", ps_mon, 0);
        rst = 1'b0;
        wait_ps(cyc);
        check("c_rst_first_ps", cyc, 8);
        for (int p = 0; p < 3; p++) begin
            measure(-1, 0, -1, len, h0, h1, r0, ho);
            check($sformatf("c_rst_breath_%0d", p), h0, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_dimmer.md
Name: led_pwm_dimmer

Overview:
- Parametrised successor to the fixed half-rate LED toggle; drives N LEDs on the TinyFPGA BX (16 MHz CLK).
- Each channel has a programmable duty cycle instead of a fixed 50% square wave.
- Each channel selects static-duty mode or a shared "breathing" triangle ramp.
- Sits at top level between control logic (or tie-offs) and LED pins; also drives USBPU low.

Parameters:
- N_CH, 2, number of LED channels (1..8).
- WIDTH, 8, duty/counter width in bits; PWM period = 2^WIDTH ticks.
- PRESCALE, 4, CLK cycles per PWM tick (>=1); PRESCALE=1 means a tick every cycle.
- BREATH_DIV, 2, PWM periods per breathing-level step (>=1).

Ports:
- CLK  input  1  16 MHz system clock.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  1 = run; 0 = freeze prescaler, PWM and breath counters, force LED low.
- DUTY  input  N_CH*WIDTH  per-channel duty; channel i at bits [i*WIDTH +: WIDTH].
- MODE  input  N_CH  per channel: 0 = static DUTY, 1 = breathing.
- LED  output  N_CH  registered PWM outputs.
- PERIOD_START  output  1  one-cycle pulse on the cycle the PWM counter wraps to 0.
- USBPU  output  1  constant 0 (USB disabled).

Behaviour:
- Reset (RST=1 at CLK edge) clears: prescaler=0, pwm_cnt=0, all shadow duties=0, breath_level=0, breath_dir=up, breath_div_cnt=0, LED=0, PERIOD_START=0. RST has priority over EN. Reset mid-period takes effect on the next edge with no partial pulse.
- Prescaler counts 0..PRESCALE-1 while EN=1. tick=1 on the cycle prescaler==PRESCALE-1, then it wraps to 0.
- pwm_cnt (WIDTH bits) increments on tick and wraps from 2^WIDTH-1 to 0.
- PERIOD_START=1 for exactly one cycle, registered, on the edge where pwm_cnt becomes 0 via wrap. Not asserted on reset exit.
- Shadow latch: on the wrap tick, each channel's shadow_duty is loaded with DUTY[i] (MODE[i]=0) or breath_level (MODE[i]=1). DUTY/MODE changes mid-period have no effect until the next period.
- Output: LED[i] <= EN & (pwm_cnt < shadow_duty[i]), registered; 1-cycle latency from pwm_cnt.
- Duty bounds: duty 0 means LED never high. Duty 2^WIDTH-1 means high for 2^WIDTH-1 of 2^WIDTH ticks; 100% on is not reachable by design.
- Breathing:
  - breath_div_cnt counts periods 0..BREATH_DIV-1 (advances on wrap ticks).
  - When it wraps, breath_level steps ±1.
  - Direction up: at 2^WIDTH-1, direction flips to down and the level steps to 2^WIDTH-2.
  - Direction down: at 0, direction flips to up and the level steps to 1.
  - Endpoints are held for one step only. Triangle period = 2*(2^WIDTH-1) steps.
  - A level step and the shadow load on the same wrap tick: shadow takes the pre-step level.
- EN=0: all counters hold, LED=0, PERIOD_START=0. EN returning to 1 resumes from the held state without resetting.
- All arithmetic is unsigned and modulo its declared width. No overflow beyond the stated wraps.

Decomposition:
- Package led_pwm_pkg holds:
  - MODE_STATIC=1'b0, MODE_BREATH=1'b1.
  - Default WIDTH/PRESCALE constants.
  - Function for the breathing next-level/next-direction.
- Sub-module led_pwm_channel, instantiated N_CH times. Contains: shadow register, compare, LED flop. Inputs: pwm_cnt, wrap, EN, duty source.
- Prescaler, pwm_cnt and breath generator stay in the top, shared by all channels.

Test Plan:
- Reset/static: WIDTH=4, PRESCALE=1, DUTY ch0=4, ch1=0, MODE=0 -> after first wrap, LED[0] high 4 of every 16 cycles, LED[1] constant 0. PERIOD_START pulses every 16 cycles.
- Max duty: DUTY=15, WIDTH=4 -> LED high 15 cycles, low exactly 1 cycle per period. Duty 0 -> never high.
- Shadow update: change DUTY 4->12 mid-period (pwm_cnt=7) -> current period keeps 4-high; next period is 12-high, with no extra pulse or glitch.
- Prescaler/EN: PRESCALE=3, DUTY=2 -> LED high 6 CLK per 48-cycle period. EN low for 10 cycles mid-period -> LED=0, counters frozen, period stretched by exactly 10 cycles.
- Breathing: WIDTH=3, PRESCALE=1, BREATH_DIV=1, MODE=1 -> shadow duty per period follows 0,1,…,7,6,…,0,1. PERIOD_START count between the two level-7 peaks = 14.
- Reset mid-operation: assert RST while LED=1 at breath_level=5 -> next cycle LED=0, level=0, direction up, pwm_cnt=0. Normal operation resumes after deassertion.
